volume_level_monitor: RTL and testbench
=======================================

Name: volume_level_monitor

Overview:
- Downstream consumer of the volume integrator's output stream.
- Takes integrated volume samples over a valid/ready handshake and tracks a decaying peak.
- Classifies loudness with a 4-state hysteresis FSM that qualifies each transition over consecutive samples.
- Emits loud/quiet transition events over a second valid/ready handshake to the control logic.

Parameters:
- DATA_W, 16: width of integrated volume samples and the peak register (unsigned).
- HI_THRESH, 1000: a sample at or above this value qualifies as loud.
- LO_THRESH, 600: a sample below this value qualifies as quiet. Constraint: LO_THRESH <= HI_THRESH.
- HOLD_CYCLES, 4: number of consecutive qualifying accepted samples needed to commit a transition. Constraint: HOLD_CYCLES >= 2.
- DECAY_SHIFT, 4: peak decay per accepted sample is peak >> DECAY_SHIFT.

Ports:
- clock  in  1  single clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-high.
- io_in_valid  in  1  sample valid.
- io_in_ready  out  1  block can accept a sample.
- io_in_bits  in  DATA_W  integrated volume sample (unsigned).
- io_evt_valid  out  1  transition event pending.
- io_evt_ready  in  1  consumer accepts the event.
- io_evt_loud  out  1  event type: 1 = entered LOUD, 0 = returned to QUIET.
- io_peak  out  DATA_W  current decayed peak.
- io_state  out  2  FSM state encoding: 0 QUIET, 1 ATTACK, 2 LOUD, 3 RELEASE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = QUIET, hold counter = 0, peak = 0, io_evt_valid = 0, io_evt_loud = 0.
  - io_in_ready is therefore 1 during reset.
- Input handshake:
  - io_in_ready = !io_evt_valid, driven combinationally from the evt_valid register.
  - A sample is accepted when io_in_valid && io_in_ready.
  - Nothing changes on non-accepted cycles.
- Peak update (per accepted sample s):
  - d = peak - (peak >> DECAY_SHIFT).
  - peak <= (s > d) ? s : d.
  - Unsigned, no overflow possible. io_peak is the register output, so the update appears one cycle after acceptance.
- Hold counter: width clog2(HOLD_CYCLES+1); counts consecutive qualifying samples, including the one that entered the current state.
- FSM transitions (evaluated only on accepted samples):
  - QUIET: s >= HI_THRESH -> ATTACK, cnt = 1. Otherwise stay.
  - ATTACK, s >= HI_THRESH: if cnt+1 == HOLD_CYCLES -> LOUD, cnt = 0, raise event with loud = 1. Else cnt++.
  - ATTACK, s < HI_THRESH: -> QUIET, cnt = 0, no event.
  - LOUD: s < LO_THRESH -> RELEASE, cnt = 1. Otherwise stay.
  - RELEASE, s < LO_THRESH: if cnt+1 == HOLD_CYCLES -> QUIET, cnt = 0, raise event with loud = 0. Else cnt++.
  - RELEASE, s >= LO_THRESH: -> LOUD, cnt = 0, no event.
  - Samples in [LO_THRESH, HI_THRESH) hold LOUD and QUIET and do not disturb them.
- Event output:
  - io_evt_valid and io_evt_loud are registered and assert in the cycle after the committing sample is accepted.
  - The event is held stable until io_evt_valid && io_evt_ready.
  - io_evt_valid clears at the next edge; io_in_ready returns to 1 the cycle after acceptance.
  - No event can be lost: the input is stalled while an event is pending, so no second event can be generated.
- io_state is a direct register output, updated at the edge that accepts the sample.
- Reset mid-operation:
  - A pending event is discarded.
  - A partial ATTACK/RELEASE count is lost.
  - The peak is cleared.
- Latency: state has 1 edge latency from acceptance; peak and event also have 1 cycle latency.

Test Plan (defaults: DATA_W=16, HI=1000, LO=600, HOLD=4, SHIFT=4):
1. Assert reset, then release -> io_state=0, io_peak=0, io_evt_valid=0, io_in_ready=1.
2. Four back-to-back accepted samples of 1200, io_evt_ready=1 -> io_state goes 1,1,1,2. io_evt_valid=1 with io_evt_loud=1 for one cycle after the 4th accept. io_in_ready=0 in that cycle.
3. Samples 1200,1200,1200,500 from QUIET -> io_state goes 1,1,1,0. io_evt_valid stays 0.
4. From LOUD: samples 500 then 700 -> io_state goes 3 then 2. Then four samples of 500 with io_evt_ready=0 for 5 cycles:
   - io_state reaches 0 and io_evt_valid=1 with io_evt_loud=0.
   - The event stays held, io_in_ready=0, and a further sample of 1200 with valid=1 is not accepted (peak unchanged).
   - Raise io_evt_ready: event clears, io_in_ready=1 next cycle.
5. From reset: accept 1600, then 0,0,0 -> io_peak goes 1600, 1500, 1407, 1320.
6. In ATTACK (cnt=2, peak=1200): assert reset between clock edges -> io_state=0, io_peak=0, io_evt_valid=0 before the next edge. After release, 3 samples of 1200 give no event (count restarts).

Source files
------------

// File: rtl/volume_level_monitor.sv
// Volume level monitor: keeps a decaying peak of accepted samples, classifies
// loudness with a qualified hysteresis FSM and reports loud/quiet transitions.
module volume_level_monitor #(
  parameter int DATA_W      = 16,
  parameter int HI_THRESH   = 1000,
  parameter int LO_THRESH   = 600,
  parameter int HOLD_CYCLES = 4,
  parameter int DECAY_SHIFT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_bits,
  output logic              io_evt_valid,
  input  logic              io_evt_ready,
  output logic              io_evt_loud,
  output logic [DATA_W-1:0] io_peak,
  output logic [1:0]        io_state
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DATA_W-1:0] HI_T = DATA_W'(HI_THRESH);
  localparam logic [DATA_W-1:0] LO_T = DATA_W'(LO_THRESH);
  // Count value whose next qualifying sample commits the transition.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_QUIET   = 2'd0,
    S_ATTACK  = 2'd1,
    S_LOUD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic              evt_valid_q, evt_valid_d;
  logic              evt_loud_q, evt_loud_d;

  logic              accept;
  logic              is_hi, is_lo;
  logic [DATA_W-1:0] decayed;

  assign accept  = io_in_valid && !evt_valid_q;
  assign is_hi   = io_in_bits >= HI_T;
  assign is_lo   = io_in_bits < LO_T;
  assign decayed = peak_q - (peak_q >> DECAY_SHIFT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    peak_d      = peak_q;
    evt_valid_d = evt_valid_q;
    evt_loud_d  = evt_loud_q;

    if (evt_valid_q && io_evt_ready) evt_valid_d = 1'b0;

    // Input is stalled while an event is pending, so a commit never
    // collides with the pending event above.
    if (accept) begin
      peak_d = (io_in_bits > decayed) ? io_in_bits : decayed;
      unique case (state_q)
        S_QUIET: begin
          if (is_hi) begin
            state_d = S_ATTACK;
            cnt_d   = CNT_W'(1);
          end
        end
        S_ATTACK: begin
          if (!is_hi) begin
            state_d = S_QUIET;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d     = S_LOUD;
            cnt_d       = '0;
            evt_valid_d = 1'b1;
            evt_loud_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_LOUD: begin
          if (is_lo) begin
            state_d = S_RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (!is_lo) begin
            state_d = S_LOUD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d     = S_QUIET;
            cnt_d       = '0;
            evt_valid_d = 1'b1;
            evt_loud_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_QUIET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_QUIET;
      cnt_q       <= '0;
      peak_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_loud_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      peak_q      <= peak_d;
      evt_valid_q <= evt_valid_d;
      evt_loud_q  <= evt_loud_d;
    end
  end

  assign io_in_ready  = !evt_valid_q;
  assign io_evt_valid = evt_valid_q;
  assign io_evt_loud  = evt_loud_q;
  assign io_peak      = peak_q;
  assign io_state     = state_q;
endmodule

// File: tb/tb_volume_level_monitor.sv
// Bench for volume_level_monitor: directed scenarios followed by random
// traffic, all checked against a sample-level behavioural model.
module tb_volume_level_monitor;
  localparam int DATA_W = 16;
  localparam int HI     = 1000;
  localparam int LO     = 600;
  localparam int HOLD   = 4;
  localparam int SHIFT  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              io_in_valid = 1'b0;
  logic              io_in_ready;
  logic [DATA_W-1:0] io_in_bits = '0;
  logic              io_evt_valid;
  logic              io_evt_ready = 1'b0;
  logic              io_evt_loud;
  logic [DATA_W-1:0] io_peak;
  logic [1:0]        io_state;

  volume_level_monitor #(
    .DATA_W(DATA_W), .HI_THRESH(HI), .LO_THRESH(LO),
    .HOLD_CYCLES(HOLD), .DECAY_SHIFT(SHIFT)
  ) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
    .io_evt_valid(io_evt_valid), .io_evt_ready(io_evt_ready), .io_evt_loud(io_evt_loud),
    .io_peak(io_peak), .io_state(io_state)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: 0 quiet, 1 attack, 2 loud, 3 release; run = qualifying samples so far.
  int m_state, m_run, m_peak;
  bit m_ev, m_loud;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_run = 0; m_peak = 0; m_ev = 0; m_loud = 0;
  endtask

  task automatic model_edge(input bit v, input int s, input bit r);
    bit acc;
    int d;
    acc = v && !m_ev;
    if (m_ev && r) m_ev = 0;
    if (acc) begin
      d = m_peak - m_peak / (1 << SHIFT);
      m_peak = (s > d) ? s : d;
      case (m_state)
        0: if (s >= HI) begin m_state = 1; m_run = 1; end
        1: if (s < HI) begin m_state = 0; m_run = 0; end
           else if (m_run + 1 == HOLD) begin m_state = 2; m_run = 0; m_ev = 1; m_loud = 1; end
           else m_run++;
        2: if (s < LO) begin m_state = 3; m_run = 1; end
        default:
           if (s >= LO) begin m_state = 2; m_run = 0; end
           else if (m_run + 1 == HOLD) begin m_state = 0; m_run = 0; m_ev = 1; m_loud = 0; end
           else m_run++;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  32'(io_state),     32'(m_state));
    chk({tag, ".peak"},   32'(io_peak),      32'(m_peak));
    chk({tag, ".evt_v"},  32'(io_evt_valid), 32'(m_ev));
    chk({tag, ".evt_l"},  32'(io_evt_loud),  32'(m_loud));
    chk({tag, ".in_rdy"}, 32'(io_in_ready),  32'(!m_ev));
  endtask

  // Drive inputs, take one edge, then compare 1 time unit after it.
  task automatic step(input string tag, input bit v, input int s, input bit r);
    io_in_valid  = v;
    io_in_bits   = DATA_W'(s);
    io_evt_ready = r;
    @(posedge clock);
    model_edge(v, s, r);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    io_in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    // 1: reset state
    do_reset();

    // 2: enter LOUD after four high samples
    for (int i = 0; i < 4; i++) step("t2", 1, 1200, 1);
    chk("t2.evt_fixed", 32'(io_evt_valid), 32'd1);
    chk("t2.state_fixed", 32'(io_state), 32'd2);
    step("t2c", 0, 0, 1);
    chk("t2.evt_cleared", 32'(io_evt_valid), 32'd0);

    // 4: release aborted, then a release held against a stalled consumer
    step("t4a", 1, 500, 1);
    chk("t4.release", 32'(io_state), 32'd3);
    step("t4b", 1, 700, 1);
    chk("t4.back_loud", 32'(io_state), 32'd2);
    for (int i = 0; i < 4; i++) step("t4c", 1, 500, 0);
    chk("t4.quiet_evt", 32'(io_evt_valid), 32'd1);
    chk("t4.quiet_loud", 32'(io_evt_loud), 32'd0);
    for (int i = 0; i < 2; i++) step("t4stall", 1, 1200, 0);
    chk("t4.stall_state", 32'(io_state), 32'd0);
    step("t4clr", 0, 0, 1);
    chk("t4.in_ready", 32'(io_in_ready), 32'd1);

    // 3: aborted attack raises no event
    for (int i = 0; i < 3; i++) step("t3", 1, 1200, 1);
    step("t3end", 1, 500, 1);
    chk("t3.state", 32'(io_state), 32'd0);
    chk("t3.no_evt", 32'(io_evt_valid), 32'd0);

    // 5: peak decay sequence
    do_reset();
    step("t5a", 1, 1600, 1);
    chk("t5.p0", 32'(io_peak), 32'd1600);
    step("t5b", 1, 0, 1);
    chk("t5.p1", 32'(io_peak), 32'd1500);
    step("t5c", 1, 0, 1);
    chk("t5.p2", 32'(io_peak), 32'd1407);
    step("t5d", 1, 0, 1);
    chk("t5.p3", 32'(io_peak), 32'd1320);

    // 6: asynchronous reset in the middle of an attack
    do_reset();
    step("t6a", 1, 1200, 1);
    step("t6b", 1, 1200, 1);
    chk("t6.attack", 32'(io_state), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t6async");
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("t6c", 1, 1200, 1);
    chk("t6.no_evt", 32'(io_evt_valid), 32'd0);
    chk("t6.still_attack", 32'(io_state), 32'd1);

    // Random traffic biased around the thresholds
    for (int i = 0; i < 400; i++) begin
      int s;
      int kind;
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: s = int'($urandom_range(0, LO - 1));
        1: s = int'($urandom_range(LO, HI - 1));
        2: s = int'($urandom_range(HI, 4000));
        default: s = int'($urandom_range(0, 65535));
      endcase
      step("rnd", ($urandom_range(0, 9) < 8), s, ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
